acs_pm_unit: RTL and testbench

// - Add-compare-select and path-metric store for the K=7, 64-state, rate-1/2 Viterbi decoder.
// - Sits directly downstream of the per-state branch-metric (BMC) array and consumes its 2-bit hard-decision metrics.
// - Each accepted trellis step updates 64 path metrics and emits one 64-bit survivor decision vector.
// - The decision vector feeds the traceback memory.

---
 rtl/acs_pm_unit.sv | 103 ++++++++++
 tb/tb_acs_pm_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/acs_pm_unit.sv
// Add-compare-select and path-metric store for the K=7, 64-state, rate-1/2 Viterbi decoder.
// Optional ACS_BEST_STATE_EN adds best_state/best_pm (minimum new metric and its index).
module acs_pm_unit #(
   parameter int N_STATE = 64,
   parameter int PM_W    = 8,
   parameter int INIT_PM = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bm_valid,
   input  logic [4*N_STATE-1:0] bm_bus,
   output logic                 dec_valid,
   output logic [N_STATE-1:0]   dec_bits,
   output logic                 norm_pulse,
`ifdef ACS_BEST_STATE_EN
   output logic [5:0]           best_state,
   output logic [PM_W-1:0]      best_pm,
`endif
   output logic [15:0]          step_cnt
);

   logic [PM_W-1:0]    pm      [N_STATE];
   logic [PM_W-1:0]    pm_src  [N_STATE];
   logic [PM_W-1:0]    cand    [N_STATE];
   logic [PM_W-1:0]    pm_next [N_STATE];
   logic [N_STATE-1:0] dec_n;
   logic               all_msb;
`ifdef ACS_BEST_STATE_EN
   logic [5:0]         best_idx_n;
   logic [PM_W-1:0]    best_pm_n;
`endif

   function automatic logic [PM_W-1:0] init_pm(input int unsigned s);
      return (s == 0) ? '0 : PM_W'(INIT_PM);
   endfunction

   // A start coinciding with bm_valid computes the step from the initial metrics.
   always_comb begin
      all_msb = 1'b1;
      dec_n   = '0;
      for (int unsigned s = 0; s < N_STATE; s++) begin
         pm_src[s] = start ? init_pm(s) : pm[s];
      end
      for (int unsigned j = 0; j < N_STATE; j++) begin
         int unsigned     p0, p1;
         logic [PM_W-1:0] c0, c1;
         p0 = j >> 1;
         p1 = p0 + N_STATE / 2;
         c0 = pm_src[p0] + PM_W'(bm_bus[4*p0 + 2*(j%2) +: 2]);
         c1 = pm_src[p1] + PM_W'(bm_bus[4*p1 + 2*(j%2) +: 2]);
         dec_n[j] = (c1 < c0);
         cand[j]  = (c1 < c0) ? c1 : c0;
         all_msb  = all_msb & cand[j][PM_W-1];
      end
      for (int unsigned j = 0; j < N_STATE; j++) begin
         pm_next[j] = all_msb ? {1'b0, cand[j][PM_W-2:0]} : cand[j];
      end
   end

`ifdef ACS_BEST_STATE_EN
   always_comb begin
      best_idx_n = '0;
      best_pm_n  = pm_next[0];
      for (int unsigned j = 1; j < N_STATE; j++) begin
         if (pm_next[j] < best_pm_n) begin
            best_pm_n  = pm_next[j];
            best_idx_n = 6'(j);
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < N_STATE; s++) pm[s] <= init_pm(s);
         dec_valid  <= 1'b0;
         dec_bits   <= '0;
         norm_pulse <= 1'b0;
         step_cnt   <= '0;
`ifdef ACS_BEST_STATE_EN
         best_state <= '0;
         best_pm    <= '0;
`endif
      end else begin
         dec_valid  <= bm_valid;
         norm_pulse <= bm_valid & all_msb;
         if (bm_valid) begin
            for (int unsigned s = 0; s < N_STATE; s++) pm[s] <= pm_next[s];
            dec_bits <= dec_n;
            step_cnt <= start ? 16'd1 : step_cnt + 16'd1;
`ifdef ACS_BEST_STATE_EN
            best_state <= best_idx_n;
            best_pm    <= best_pm_n;
`endif
         end else if (start) begin
            for (int unsigned s = 0; s < N_STATE; s++) pm[s] <= init_pm(s);
            step_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_acs_pm_unit.sv
// Self-checking bench for acs_pm_unit against a forward-trellis reference model.
module tb_acs_pm_unit;

   logic         clk = 1'b0;
   logic         rst, start, bm_valid;
   logic [255:0] bm_bus;
   logic         dec_valid, norm_pulse;
   logic [63:0]  dec_bits;
   logic [15:0]  step_cnt;
`ifdef ACS_BEST_STATE_EN
   logic [5:0]   best_state;
   logic [7:0]   best_pm;
`endif

   acs_pm_unit #(.N_STATE(64), .PM_W(8), .INIT_PM(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bm_valid   (bm_valid),
      .bm_bus     (bm_bus),
      .dec_valid  (dec_valid),
      .dec_bits   (dec_bits),
      .norm_pulse (norm_pulse),
`ifdef ACS_BEST_STATE_EN
      .best_state (best_state),
      .best_pm    (best_pm),
`endif
      .step_cnt   (step_cnt)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          m_pm [64];
   logic [63:0] exp_dec;
   logic        exp_norm;
   int          exp_cnt;
   int          exp_best_idx, exp_best_pm;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_init();
      for (int s = 0; s < 64; s++) m_pm[s] = (s == 0) ? 0 : 32;
      exp_cnt = 0;
   endfunction

   // Forward view: every state s with input b contributes a candidate to state (2s+b) mod 64.
   function automatic void model_step(input logic [255:0] bm);
      int          best [64];
      int          from [64];
      logic [255:0] t;
      int          c, j;
      bit          all_hi;
      for (int k = 0; k < 64; k++) best[k] = -1;
      for (int s = 0; s < 64; s++) begin
         for (int b = 0; b < 2; b++) begin
            j = (s * 2 + b) % 64;
            t = bm >> (4 * s + 2 * b);
            c = m_pm[s] + int'(t[1:0]);
            if (best[j] < 0 || c < best[j]) begin
               best[j] = c;
               from[j] = s;
            end
         end
      end
      all_hi = 1'b1;
      for (int k = 0; k < 64; k++) begin
         exp_dec[k] = (from[k] >= 32);
         if (best[k] < 128) all_hi = 1'b0;
      end
      exp_norm     = all_hi;
      exp_best_pm  = 1000;
      exp_best_idx = 0;
      for (int k = 0; k < 64; k++) begin
         m_pm[k] = all_hi ? best[k] - 128 : best[k];
         if (m_pm[k] < exp_best_pm) begin
            exp_best_pm  = m_pm[k];
            exp_best_idx = k;
         end
      end
      exp_cnt = (exp_cnt + 1) % 65536;
   endfunction

   function automatic logic [255:0] rand_bm();
      logic [255:0] v = '0;
      for (int s = 0; s < 128; s++) v[2*s +: 2] = 2'($urandom_range(0, 2));
      return v;
   endfunction

   function automatic logic [255:0] fill_bm(input logic [3:0] nib);
      logic [255:0] v;
      for (int s = 0; s < 64; s++) v[4*s +: 4] = nib;
      return v;
   endfunction

   task automatic check_pm(input string tag);
      logic [511:0] obs, exp;
      for (int s = 0; s < 64; s++) begin
         obs[8*s +: 8] = dut.pm[s];
         exp[8*s +: 8] = 8'(m_pm[s]);
      end
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed_pm0=%0d expected_pm0=%0d (metric array differs)", tag, obs[7:0], exp[7:0]);
      end
   endtask

   task automatic check_step(input string tag);
      check({tag, "_valid"}, 64'(dec_valid), 64'd1);
      check({tag, "_dec"}, dec_bits, exp_dec);
      check({tag, "_norm"}, 64'(norm_pulse), 64'(exp_norm));
      check({tag, "_cnt"}, 64'(step_cnt), 64'(exp_cnt));
`ifdef ACS_BEST_STATE_EN
      check({tag, "_bidx"}, 64'(best_state), 64'(exp_best_idx));
      check({tag, "_bpm"}, 64'(best_pm), 64'(exp_best_pm));
`endif
   endtask

   task automatic do_step(input string tag, input logic [255:0] bm, input logic st);
      @(negedge clk);
      bm_bus = bm; bm_valid = 1'b1; start = st;
      if (st) model_init();
      model_step(bm);
      @(posedge clk); #1;
      bm_valid = 1'b0; start = 1'b0;
      check_step(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_init();
   endtask

   initial begin
      logic [63:0]  save_dec;
      logic [15:0]  save_cnt;
      logic [255:0] bm;
      int           norm_seen;
      rst = 1'b1; start = 1'b0; bm_valid = 1'b0; bm_bus = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_init();
      check("rst_valid", 64'(dec_valid), 64'd0);
      check("rst_dec", dec_bits, 64'd0);
      check("rst_norm", 64'(norm_pulse), 64'd0);
      check("rst_cnt", 64'(step_cnt), 64'd0);
      check_pm("rst_pm");

      do_step("zero", '0, 1'b0);
      check("zero_dec_lit", dec_bits, 64'd0);
      check("zero_cnt_lit", 64'(step_cnt), 64'd1);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         do_step("in0_zero", fill_bm(4'b1000), 1'b0);
         check("in0_pm0", 64'(dut.pm[0]), 64'd0);
         check("in0_dec0", 64'(dec_bits[0]), 64'd0);
      end

      do_reset();
      norm_seen = 0;
      for (int i = 1; i <= 64; i++) begin
         do_step("all2", fill_bm(4'b1010), 1'b0);
         if (norm_pulse) norm_seen++;
      end
      check("all2_norm_last", 64'(norm_pulse), 64'd1);
      check("all2_norm_once", 64'(norm_seen), 64'd1);
      check("all2_pm0", 64'(dut.pm[0]), 64'd0);
      check_pm("all2_pm");
      do_step("all2_after", fill_bm(4'b1010), 1'b0);

      for (int i = 0; i < 20; i++) do_step("rand", rand_bm(), 1'b0);
      check_pm("rand_pm");

      save_dec = dec_bits;
      save_cnt = step_cnt;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("idle_valid", 64'(dec_valid), 64'd0);
         check("idle_norm", 64'(norm_pulse), 64'd0);
      end
      check("idle_cnt", 64'(step_cnt), 64'(exp_cnt));
      check("idle_dec", dec_bits, save_dec);
      check_pm("idle_pm");
      for (int i = 0; i < 5; i++) do_step("resume", rand_bm(), 1'b0);

      bm = rand_bm();
      do_step("start_bm", bm, 1'b1);
      check("start_cnt1", 64'(step_cnt), 64'd1);
      save_dec = dec_bits;
      do_reset();
      do_step("fresh_bm", bm, 1'b0);
      check("start_eq_fresh", dec_bits, save_dec);

      do_step("pre_rst", rand_bm(), 1'b0);
      do_reset();
      check("midrst_valid", 64'(dec_valid), 64'd0);
      check("midrst_dec", dec_bits, 64'd0);
      check("midrst_cnt", 64'(step_cnt), 64'd0);
      check_pm("midrst_pm");
      do_step("post_rst", rand_bm(), 1'b0);

      for (int i = 0; i < 3; i++) do_step("more", rand_bm(), 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      model_init();
      check("start_only_valid", 64'(dec_valid), 64'd0);
      check("start_only_cnt", 64'(step_cnt), 64'd0);
      check_pm("start_only_pm");
      for (int i = 0; i < 150; i++) do_step("long", rand_bm(), 1'b0);
      check_pm("long_pm");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
